// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for the single-port node memory.
//   The memory has a 16-bit word port, is byte-addressed, reads combinationally and writes on posedge.
//   Requester A is the packet handler. Requester B is the Q-learning engine.
//   Each access is sequenced through an IDLE -> SERVE_x -> IDLE cycle.
//   A bounded lock lets the current owner stay in SERVE_x for read-modify-write bursts.
//
// Optional feature: define MEM_ARB_ADDR_CHECK_EN to reject odd or out-of-range addresses.
//   A rejected access has no write and no rvalid, and pulses err for one cycle.
//   Without the macro the err port does not exist and every address is passed through.
//
// Ports
//   clock, reset           system clock; synchronous active-high reset
//   x_req/x_lock/x_wr      request, keep-grant-after-access, write(1)/read(0)   (x = a, b)
//   x_addr/x_wdata         byte address (even) and write data
//   x_gnt                  x owns the memory this cycle; the access fires when x_req && x_gnt
//   x_rdata/x_rvalid       registered read data, with a 1-cycle valid pulse after a fired read
//   mem_address/mem_wr_en/mem_data_in   drive the memory; mem_data_out is its read data
//   err                    (MEM_ARB_ADDR_CHECK_EN only) 1-cycle pulse after a rejected access
//   state_dbg              current FSM state: 0=IDLE, 1=SERVE_A, 2=SERVE_B
//
// Handshake: a requester raises x_req and holds x_wr/x_addr/x_wdata stable until it sees x_gnt.
//   The access is taken on the clock edge that ends a cycle in which x_req && x_gnt is true.
//   x_gnt is purely registered, so there is no combinational path from req to gnt.
module mem_arbiter #(
    parameter int WORD_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_lock,
    input  logic                  a_wr,
    input  logic [WORD_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [WORD_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_lock,
    input  logic                  b_wr,
    input  logic [WORD_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [WORD_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [WORD_WIDTH-1:0] mem_address,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
`ifdef MEM_ARB_ADDR_CHECK_EN
    output logic                  err,
`endif
    output logic [1:0]            state_dbg
);

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);
    // The last legal word starts at MEM_DEPTH-2. A higher address would cross the end of memory.
    localparam logic [WORD_WIDTH-1:0] ADDR_MAX = WORD_WIDTH'(MEM_DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              prio, prio_nxt;          // 0 = A wins a tie, 1 = B wins a tie
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;      // accesses already taken in this locked run, minus one

    logic fire_a, fire_b;
    logic a_ok, b_ok;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prio     <= prio_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        lock_nxt  = lock_cnt;
        case (state)
            IDLE: begin
                if (a_req && (!b_req || !prio)) begin
                    state_nxt = SERVE_A;
                end else if (b_req) begin
                    state_nxt = SERVE_B;
                end
            end
            SERVE_A: begin
                // Stay only while locked and under the cap. Any exit hands the tie-break to B.
                if (a_req && a_lock && (lock_cnt < LOCK_LAST)) begin
                    lock_nxt = lock_cnt + LOCK_W'(1);
                end else begin
                    state_nxt = IDLE;
                    lock_nxt  = '0;
                    prio_nxt  = 1'b1;
                end
            end
            SERVE_B: begin
                if (b_req && b_lock && (lock_cnt < LOCK_LAST)) begin
                    lock_nxt = lock_cnt + LOCK_W'(1);
                end else begin
                    state_nxt = IDLE;
                    lock_nxt  = '0;
                    prio_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                lock_nxt  = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        fire_a      = (state == SERVE_A) && a_req;
        fire_b      = (state == SERVE_B) && b_req;
        a_ok        = !ADDR_CHECK || !(a_addr[0] || (a_addr > ADDR_MAX));
        b_ok        = !ADDR_CHECK || !(b_addr[0] || (b_addr > ADDR_MAX));
        mem_address = '0;
        mem_data_in = '0;
        mem_wr_en   = 1'b0;
        if (state == SERVE_A) begin
            mem_address = a_addr;
            mem_data_in = a_wdata;
            // Gated by reset so that a write is never taken on a reset edge.
            mem_wr_en   = a_wr && fire_a && a_ok && !reset;
        end else if (state == SERVE_B) begin
            mem_address = b_addr;
            mem_data_in = b_wdata;
            mem_wr_en   = b_wr && fire_b && b_ok && !reset;
        end
    end

    assign a_gnt     = (state == SERVE_A);
    assign b_gnt     = (state == SERVE_B);
    assign state_dbg = state;

    // Read return path. Each requester's rdata holds its value until that requester's next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= fire_a && !a_wr && a_ok;
            b_rvalid <= fire_b && !b_wr && b_ok;
            if (fire_a && !a_wr && a_ok) begin
                a_rdata <= mem_data_out;
            end
            if (fire_b && !b_wr && b_ok) begin
                b_rdata <= mem_data_out;
            end
        end
    end

`ifdef MEM_ARB_ADDR_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (fire_a && !a_ok) || (fire_b && !b_ok);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
//   The bench models the memory itself: 512 words, combinational read, posedge write.
//   Read data is scoreboarded through per-requester expected queues.
//   Grants, memory controls and pulses are compared against hand-derived values, cycle by cycle.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_lock = 1'b0, a_wr = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        b_req = 1'b0, b_lock = 1'b0, b_wr = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_wr_en;
    logic [15:0] a_rdata, b_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  state_dbg;
`ifdef MEM_ARB_ADDR_CHECK_EN
    logic        err;
`endif

    logic [15:0] mem [0:511];
    logic [15:0] exp_a_q [$];
    logic [15:0] exp_b_q [$];
    int          n_total = 0;
    int          n_bad   = 0;

    mem_arbiter #(.WORD_WIDTH(16), .MEM_DEPTH(1024), .MAX_LOCK(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .a_req        (a_req),
        .a_lock       (a_lock),
        .a_wr         (a_wr),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_gnt        (a_gnt),
        .a_rdata      (a_rdata),
        .a_rvalid     (a_rvalid),
        .b_req        (b_req),
        .b_lock       (b_lock),
        .b_wr         (b_wr),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_gnt        (b_gnt),
        .b_rdata      (b_rdata),
        .b_rvalid     (b_rvalid),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
`ifdef MEM_ARB_ADDR_CHECK_EN
        .err          (err),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock
    always #5 clock = ~clock;

    // Memory model
    assign mem_data_out = mem[mem_address[9:1]];
    always @(posedge clock) begin
        if (mem_wr_en) mem[mem_address[9:1]] <= mem_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rvalid pulse must match the oldest expected read for that requester.
    always @(negedge clock) begin
        if (a_rvalid) begin
            if (exp_a_q.size() == 0) check("a_rvalid_unexpected", 1, 0);
            else check("a_rdata", a_rdata, exp_a_q.pop_front());
        end
        if (b_rvalid) begin
            if (exp_b_q.size() == 0) check("b_rvalid_unexpected", 1, 0);
            else check("b_rdata", b_rdata, exp_b_q.pop_front());
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic lock, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata);
        a_req = req; a_lock = lock; a_wr = wr; a_addr = addr; a_wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic lock, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata);
        b_req = req; b_lock = lock; b_wr = wr; b_addr = addr; b_wdata = wdata;
    endtask

    task automatic do_reset();
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int a_cnt;
        logic drop_a, drop_b;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0] = 16'h000F;
        mem[1] = 16'h000E;

        // Reset state
        do_reset();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_state", state_dbg, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wr", mem_wr_en, 0);

        // 1: A reads 0x0002
        drive_a(1, 0, 0, 16'h0002, 0);
        #1 check("t1_no_comb_gnt", a_gnt, 0);
        tick();
        check("t1_a_gnt", a_gnt, 1);
        check("t1_b_gnt", b_gnt, 0);
        check("t1_state", state_dbg, 1);
        check("t1_mem_addr", mem_address, 16'h0002);
        exp_a_q.push_back(16'h000E);
        tick();
        drive_a(0, 0, 0, 0, 0);
        check("t1_a_gnt_off", a_gnt, 0);
        check("t1_a_rvalid", a_rvalid, 1);
        check("t1_a_rdata", a_rdata, 16'h000E);
        check("t1_b_gnt_2", b_gnt, 0);
        tick();
        check("t1_rvalid_pulse", a_rvalid, 0);
        check("t1_rdata_hold", a_rdata, 16'h000E);

        // 2: simultaneous A write / B read of word 0
        do_reset();
        drive_a(1, 0, 1, 16'h0000, 16'h1234);
        drive_b(1, 0, 0, 16'h0000, 0);
        tick();
        check("t2_a_gnt", a_gnt, 1);
        check("t2_b_gnt", b_gnt, 0);
        check("t2_mem_wr", mem_wr_en, 1);
        check("t2_mem_din", mem_data_in, 16'h1234);
        tick();
        drive_a(0, 0, 0, 0, 0);
        check("t2_idle_a", a_gnt, 0);
        check("t2_idle_b", b_gnt, 0);
        check("t2_no_a_rvalid", a_rvalid, 0);
        check("t2_mem_word0", mem[0], 16'h1234);
        tick();
        check("t2_b_gnt", b_gnt, 1);
        check("t2_b_mem_wr", mem_wr_en, 0);
        exp_b_q.push_back(16'h1234);
        tick();
        drive_b(0, 0, 0, 0, 0);
        check("t2_b_rvalid", b_rvalid, 1);
        check("t2_b_rdata", b_rdata, 16'h1234);

        // 3: continuous unlocked requests alternate A, B
        do_reset();
        drive_a(1, 0, 0, 16'h0000, 0);
        drive_b(1, 0, 0, 16'h0002, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t3_a_gnt_c%0d", k), a_gnt, (k % 4) == 1);
            check($sformatf("t3_b_gnt_c%0d", k), b_gnt, (k % 4) == 3);
            if (a_gnt) exp_a_q.push_back(16'h1234);
            if (b_gnt) exp_b_q.push_back(16'h000E);
        end
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        tick();
        tick();

        // 4: A locked burst of 12 reads with B waiting; cap of 8
        do_reset();
        drive_a(1, 1, 0, 16'h0002, 0);
        drive_b(1, 0, 0, 16'h0000, 0);
        a_cnt  = 0;
        drop_a = 1'b0;
        drop_b = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (drop_a) begin a_req = 1'b0; drop_a = 1'b0; end
            if (drop_b) begin b_req = 1'b0; drop_b = 1'b0; end
            check($sformatf("t4_a_gnt_c%0d", k), a_gnt, (k <= 8) || (k >= 12 && k <= 15));
            check($sformatf("t4_b_gnt_c%0d", k), b_gnt, k == 10);
            if (a_gnt && a_req) begin
                a_cnt++;
                exp_a_q.push_back(16'h000E);
                if (a_cnt == 12) begin
                    a_lock = 1'b0;
                    drop_a = 1'b1;
                end
            end
            if (b_gnt && b_req) begin
                exp_b_q.push_back(16'h1234);
                drop_b = 1'b1;
            end
        end
        check("t4_a_count", a_cnt, 12);

        // 5: reset during a write in SERVE_A
        mem[0] = 16'h000F;
        do_reset();
        drive_a(1, 0, 1, 16'h0000, 16'hBEEF);
        tick();
        check("t5_a_gnt", a_gnt, 1);
        reset = 1'b1;
        #1 check("t5_wr_gated", mem_wr_en, 0);
        tick();
        check("t5_mem_word0", mem[0], 16'h000F);
        check("t5_a_gnt_rst", a_gnt, 0);
        check("t5_state_rst", state_dbg, 0);
        drive_a(1, 0, 0, 16'h0002, 0);
        tick();
        check("t5_no_rvalid", a_rvalid, 0);
        reset = 1'b0;
        tick();
        check("t5_rearb_gnt", a_gnt, 1);
        exp_a_q.push_back(16'h000E);
        tick();
        drive_a(0, 0, 0, 0, 0);
        check("t5_rearb_rvalid", a_rvalid, 1);
        tick();

`ifdef MEM_ARB_ADDR_CHECK_EN
        // 6: B write to an odd, out-of-range address is rejected
        do_reset();
        drive_b(1, 0, 1, 16'h03FF, 16'hAAAA);
        tick();
        check("t6_b_gnt", b_gnt, 1);
        check("t6_wr_blocked", mem_wr_en, 0);
        check("t6_err_early", err, 0);
        tick();
        drive_b(0, 0, 0, 0, 0);
        drive_a(1, 0, 0, 16'h0002, 0);
        check("t6_err_pulse", err, 1);
        check("t6_no_b_rvalid", b_rvalid, 0);
        tick();
        check("t6_err_clear", err, 0);
        check("t6_a_gnt", a_gnt, 1);
        exp_a_q.push_back(16'h000E);
        tick();
        drive_a(0, 0, 0, 0, 0);
        check("t6_a_rvalid", a_rvalid, 1);
        tick();
`endif

        tick();
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
